// File: rtl/seq_mult_ctrl_dp.sv
// seq_mult_ctrl_dp
//   Control FSM and shift-add datapath for an unsigned WIDTH x WIDTH sequential
//   multiplier. A start in IDLE captures both operands. Each CALC cycle then
//   performs one partial-product step. A companion step timer, instantiated
//   outside this block with final_value = WIDTH-1, tells the FSM which step is
//   the last one. The 2*WIDTH-bit result is registered into product, and done
//   pulses for one cycle.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous reset, active low
//   start        : begin request, only looked at in IDLE
//   multiplicand : operand A, captured on an accepted start
//   multiplier   : operand B, captured on an accepted start
//   tmr_done     : timer flag, high while its count == WIDTH-1
//   tmr_enable   : timer count enable (CALC only)
//   tmr_clear    : timer synchronous clear (IDLE and DONE)
//   busy         : operation in progress (CALC or DONE)
//   done         : one-cycle completion pulse (DONE)
//   product      : result register, holds until the next completion
module seq_mult_ctrl_dp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               tmr_done,
    output logic               tmr_enable,
    output logic               tmr_clear,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    // One shift-add step. The adder carry lands in the MSB of the shifted
    // pair, so no bit is ever lost, and no overflow handling is needed.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;

    assign sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign step = {sum, p_lo_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = multiplicand;
                    p_lo_d  = multiplier;
                    p_hi_d  = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                p_hi_d = step[2*WIDTH-1:WIDTH];
                p_lo_d = step[WIDTH-1:0];
                // The timer reads WIDTH-1 during the last step. The product
                // takes the post-step value, not the stale register pair.
                if (tmr_done) begin
                    product_d = step;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            product_q <= product_d;
        end
    end

    // Control outputs are pure decodes of the state register, so they
    // carry no combinational path from the inputs.
    assign tmr_enable = (state_q == S_CALC);
    assign tmr_clear  = (state_q != S_CALC);
    assign busy       = (state_q == S_CALC) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign product    = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl_dp.sv
module tb_seq_mult_ctrl_dp;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           tmr_done;
    logic           tmr_enable, tmr_clear, busy, done;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;

    seq_mult_ctrl_dp #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .tmr_done(tmr_done), .tmr_enable(tmr_enable), .tmr_clear(tmr_clear),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    // Companion step timer. It clears synchronously, counts when enabled,
    // wraps at final_value = W-1, and shares the block reset.
    int tcnt;
    always @(posedge clk or negedge reset) begin
        if (!reset)               tcnt <= 0;
        else if (tmr_clear)       tcnt <= 0;
        else if (tmr_enable)      tcnt <= (tcnt == W-1) ? 0 : tcnt + 1;
    end
    assign tmr_done = (tcnt == W-1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation. It returns the number of edges from acceptance to
    // the observed done, and the product seen in that done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [2*W-1:0] prod);
        multiplicand = a;
        multiplier   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        prod = product;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, tmr_enable, tmr_clear} !== 4'b0001 || product !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b en=%b clr=%b product=%h, want 0 0 0 1 0000",
                     busy, done, tmr_enable, tmr_clear, product);
        end
    endtask

    task automatic test_basic();
        multiplicand = 8'd13;
        multiplier   = 8'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || tmr_enable !== 1'b1 || tmr_clear !== 1'b0) begin
            failures++;
            $display("FAIL basic_accept: busy=%b en=%b clr=%b, want 1 1 0", busy, tmr_enable, tmr_clear);
        end
        for (int i = 1; i <= W + 1; i++) begin
            tick();
            checks++;
            if (done !== (i == W)) begin
                failures++;
                $display("FAIL basic_done_timing: edge k+%0d done=%b want %b", i, done, (i == W));
            end
        end
        checks++;
        if (busy !== 1'b0 || product !== 16'd143) begin
            failures++;
            $display("FAIL basic_result: busy=%b product=%0d, want 0 143", busy, product);
        end
    endtask

    task automatic test_corners();
        int lat;
        logic [2*W-1:0] p;
        run_op(8'd255, 8'd255, lat, p);
        checks++;
        if (p !== 16'hFE01 || lat != W) begin
            failures++;
            $display("FAIL max_operands: product=%h lat=%0d, want fe01 %0d", p, lat, W);
        end
        run_op(8'd0, 8'd200, lat, p);
        checks++;
        if (p !== 16'd0 || lat != W) begin
            failures++;
            $display("FAIL zero_operand: product=%0d lat=%0d, want 0 %0d", p, lat, W);
        end
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        int lat = 0;
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (product !== 16'd63 || lat != W) begin
            failures++;
            $display("FAIL busy_start_result: product=%0d lat=%0d, want 63 %0d", product, lat, W);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0 || product !== 16'd63 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_ignored: extra_done=%0d product=%0d busy=%b, want 0 63 0",
                     ndone, product, busy);
        end
    endtask

    task automatic test_back_to_back();
        int en_cnt = 0;
        int done_at[$];
        logic [2*W-1:0] prods[$];
        int clr_bad = 0;
        multiplicand = 8'd2;
        multiplier   = 8'd3;
        start = 1'b1;
        tick();
        multiplicand = 8'd4;
        multiplier   = 8'd4;
        for (int i = 0; i <= 19; i++) begin
            if (i > 0) tick();
            if (tmr_enable) en_cnt++;
            if (tmr_clear !== !tmr_enable) clr_bad++;
            if (done) begin
                done_at.push_back(i);
                prods.push_back(product);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (done_at.size() != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d, want 2", done_at.size());
        end else begin
            checks++;
            if (done_at[1] - done_at[0] != W + 2 || prods[0] !== 16'd6 || prods[1] !== 16'd16) begin
                failures++;
                $display("FAIL b2b_results: spacing=%0d p0=%0d p1=%0d, want %0d 6 16",
                         done_at[1] - done_at[0], prods[0], prods[1], W + 2);
            end
        end
        checks++;
        if (en_cnt != 2 * W || clr_bad != 0) begin
            failures++;
            $display("FAIL b2b_timer_ctrl: enable_cycles=%0d clr_mismatch=%0d, want %0d 0",
                     en_cnt, clr_bad, 2 * W);
        end
    endtask

    task automatic test_reset_midop();
        int ndone = 0;
        int lat;
        logic [2*W-1:0] p;
        multiplicand = 8'd100;
        multiplier   = 8'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || product !== '0 || tmr_clear !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: busy=%b product=%0d clr=%b done=%b, want 0 0 1 0",
                     busy, product, tmr_clear, done);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL midop_no_done: done pulses=%0d, want 0", ndone);
        end
        run_op(8'd100, 8'd50, lat, p);
        checks++;
        if (p !== 16'd5000 || lat != W) begin
            failures++;
            $display("FAIL midop_rerun: product=%0d lat=%0d, want 5000 %0d", p, lat, W);
        end
    endtask

    task automatic test_sweep_random();
        int lat;
        int bad = 0;
        logic [2*W-1:0] p;
        int unsigned a, b;
        int unsigned bs[2] = '{1, 128};
        for (int j = 0; j < 2; j++) begin
            for (int i = 1; i <= 255; i++) begin
                run_op(W'(i), W'(bs[j]), lat, p);
                checks++;
                if (p !== 16'(i * bs[j]) || lat != W) begin
                    failures++;
                    if (bad++ < 10)
                        $display("FAIL sweep: %0d*%0d product=%0d lat=%0d, want %0d %0d",
                                 i, bs[j], p, lat, i * bs[j], W);
                end
            end
        end
        for (int n = 0; n < 1000; n++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            run_op(W'(a), W'(b), lat, p);
            checks++;
            if (p !== 16'(a * b) || lat != W) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL random: %0d*%0d product=%0d lat=%0d, want %0d %0d",
                             a, b, p, lat, a * b, W);
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        reset = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_corners();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        test_sweep_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mult_ctrl_dp.md
Name: seq_mult_ctrl_dp

Overview:
Shift-add control and datapath for the sequential 8x8 multiplier. It accepts two operands on a start request and iterates one partial-product step per clock. Step counting is delegated to the team's generic step timer (module timer, instantiated beside this block with final_value = WIDTH-1). This block drives the timer's enable/clear and consumes its done flag. It presents the 2*WIDTH-bit product with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; the companion timer's final_value must be WIDTH-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request to begin; sampled only in IDLE.
multiplicand  input  WIDTH  operand A, captured on accepted start.
multiplier  input  WIDTH  operand B, captured on accepted start.
tmr_done  input  1  done flag from companion timer (high while count == WIDTH-1).
tmr_enable  output  1  timer count enable.
tmr_clear  output  1  timer synchronous clear.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle completion pulse.
product  output  2*WIDTH  result register.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: state goes to IDLE, and the A register, P_hi, P_lo and product are cleared to 0.
- Reset values of outputs: busy=0, done=0, product=0, tmr_enable=0, tmr_clear=1.
- FSM states are IDLE, CALC and DONE. All control outputs are decoded combinationally from the state register.
  - IDLE: busy=0, tmr_clear=1, tmr_enable=0.
    - On a clock edge with start=1: load A<=multiplicand, P_lo<=multiplier, P_hi<=0, and go to CALC.
    - Otherwise hold. The timer is held at 0 throughout IDLE.
  - CALC: busy=1, tmr_enable=1, tmr_clear=0. Every edge performs one step:
    - sum[WIDTH:0] = {1'b0,P_hi} + (P_lo[0] ? A : 0).
    - {P_hi,P_lo} <= {sum, P_lo[WIDTH-1:1]}, i.e. a right shift of the (2*WIDTH+1)-bit {carry,P_hi,P_lo}.
    - If tmr_done=1 at that edge, this was step WIDTH (the last step). Load product <= the post-step {P_hi,P_lo} (the same next-state value) and go to DONE.
    - The timer wraps to 0 on that same edge, per its own behaviour.
  - DONE: busy=1, done=1, tmr_enable=0, tmr_clear=1. Unconditionally go to IDLE on the next edge. start is ignored in this state.
- Latency: start is accepted at edge k. CALC covers edges k+1..k+WIDTH. done is high for exactly the cycle after edge k+WIDTH+... more precisely, done is high during the single cycle between edge k+WIDTH and edge k+WIDTH+1. The next start can be accepted at edge k+WIDTH+2, giving a throughput of one product per WIDTH+2 cycles.
- Result holding: product holds its value from DONE until the next DONE. It is not cleared on a new start.
- Arithmetic: unsigned only. The carry out of each add is kept as the next MSB via the shift, so there is no overflow. The maximum result is (2^WIDTH-1)^2.
- start while busy (CALC or DONE): ignored, with no effect on operands or sequence. Operand inputs may change freely after acceptance.
- Operand zero: still takes the full WIDTH steps; there is no early termination.
- Reset asserted mid-operation: immediate return to IDLE with all registers at 0. The timer shares the same reset, so it also returns to 0. The aborted operation produces no done pulse.
- Defensive rule: tmr_done=1 while in IDLE or DONE is ignored.

Test Plan:
1. Reset, then start with A=13, B=11 at edge k -> busy=1 from edge k, done=1 only in the cycle after edge k+8, product=143 (0x008F), busy=0 after edge k+9.
2. A=255, B=255 -> product=65025 (0xFE01). A=0, B=200 -> product=0, with done still after exactly 8 CALC cycles.
3. Pulse start=1 with A=3, B=5 at edge k+3 of an active run (A=7, B=9) -> first result 63 is unaffected. No second done occurs. product stays 63 until a start accepted in IDLE.
4. Back-to-back operation: start held high continuously with A=2, B=3, then A=4, B=4 -> done pulses 10 cycles apart with products 6 then 16. tmr_clear is high in IDLE and DONE, and tmr_enable is high for exactly 8 cycles per operation.
5. Assert reset low for 1 cycle at CALC step 4 of A=100, B=50 -> busy=0, product=0, tmr_clear=1 immediately, no done pulse. A subsequent start with A=100, B=50 yields 5000.
6. Sweep A=1..255 against B=1 and B=128, plus 1000 random pairs against a reference model -> product == A*B at every done.
